// File: rtl/div_unit_32.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass CALC.
module div_unit_32 #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dvs;
    logic [CW-1:0]   cnt;
    logic            sign_q;
    logic            sign_r;
    logic            div_zero;
    logic            ovf;

    logic            in_signed;
    logic            in_dz;
    logic            in_ovf;
    logic [XLEN-1:0] rs1_abs;
    logic [XLEN-1:0] rs2_abs;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] trial;
    logic            borrow;
    logic            unused_trial_msb;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign in_signed = ~op[0];
    assign in_dz     = (rs2 == '0);
    assign in_ovf    = in_signed && (rs1 == MIN_NEG) && (rs2 == '1);
    assign rs1_abs   = rs1[XLEN-1] ? -rs1 : rs1;
    assign rs2_abs   = rs2[XLEN-1] ? -rs2 : rs2;

    // The dividend MSB shifts into the partial remainder; the extra top bit is the borrow.
    assign rem_sh           = {rem, dvd[XLEN-1]};
    assign trial            = {1'b0, rem_sh} - {2'b00, dvs};
    assign borrow           = trial[XLEN+1];
    assign unused_trial_msb = trial[XLEN];

    always_comb begin
        q_fix = (sign_q && !op_q[0]) ? -dvd : dvd;
        r_fix = (sign_r && !op_q[0]) ? -rem : rem;
        // Special cases are forced so the fast path can skip the iterations entirely.
        if (div_zero) begin
            q_fix = '1;
            r_fix = rs1_q;
        end else if (ovf) begin
            q_fix = MIN_NEG;
            r_fix = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            op_q     <= '0;
            rs1_q    <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !kill) begin
                        op_q     <= op;
                        rs1_q    <= rs1;
                        rem      <= '0;
                        cnt      <= '0;
                        div_zero <= in_dz;
                        ovf      <= in_ovf;
                        busy     <= 1'b1;
                        if (in_signed) begin
                            dvd    <= rs1_abs;
                            dvs    <= rs2_abs;
                            sign_q <= rs1[XLEN-1] ^ rs2[XLEN-1];
                            sign_r <= rs1[XLEN-1];
                        end else begin
                            dvd    <= rs1;
                            dvs    <= rs2;
                            sign_q <= 1'b0;
                            sign_r <= 1'b0;
                        end
`ifdef DIV_FAST_SPECIAL_EN
                        state <= (in_dz || in_ovf) ? S_FIX : S_CALC;
`else
                        state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        dvd <= {dvd[XLEN-2:0], ~borrow};
                        rem <= borrow ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_ITER) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (kill) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        result <= op_q[1] ? r_fix : q_fix;
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit_32.sv
// Self-checking bench for div_unit_32: vector table, random operands, kill/reset/start-ignore sequences.
module tb_div_unit_32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = '0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    div_unit_32 #(.XLEN(32), .ITER(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .kill(kill), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", tests, fails);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!o[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) begin
            q = MIN_NEG;
            r = 32'd0;
        end else if (!o[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (b == 32'd0) || (!o[0] && a == MIN_NEG && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_SPECIAL_EN
        return special ? 2 : 34;
`else
        return special ? 34 : 34;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input int n, input string name);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick();
            if (done) seen = 1'b1;
        end
        check_bit({name, " no done"}, seen, 1'b0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic poke_done, input string name);
        int cyc;
        logic [31:0] e;
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        exp_q.push_back(model(o, a, b));
        tick();
        start = 1'b0;
        cyc = 1;
        check_bit({name, " busy"}, busy, 1'b1);
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        if (!done) begin
            check_bit({name, " timeout"}, done, 1'b1);
            exp_q.delete();
        end else begin
            check({name, " latency"}, 32'(cyc), 32'(exp_lat(o, a, b)));
            check_bit({name, " busy at done"}, busy, 1'b0);
            e = exp_q.pop_front();
            check({name, " result"}, result, e);
            last_res = e;
            if (poke_done) begin
                start = 1'b1; op = OP_DIVU; rs1 = 32'd1; rs2 = 32'd1;
            end
            tick();
            start = 1'b0;
            check_bit({name, " done pulse"}, done, 1'b0);
            check({name, " result held"}, result, e);
            if (poke_done) begin
                check_bit({name, " start in DONE busy"}, busy, 1'b0);
                wait_quiet(40, {name, " start in DONE"});
            end
        end
    endtask

    initial begin
        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{OP_DIV,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF};
        vecs[5]  = '{OP_REM,  32'h1234_5678,  32'd0,          32'h1234_5678};
        vecs[6]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[7]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[8]  = '{OP_DIVU, 32'hDEAD_BEEF,  32'd0,          32'hFFFF_FFFF};
        vecs[9]  = '{OP_REMU, 32'hDEAD_BEEF,  32'd0,          32'hDEAD_BEEF};
        vecs[10] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[11] = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1};
        vecs[12] = '{OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};
        vecs[13] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[14] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[15] = '{OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3};

        #2;
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset done", done, 1'b0);
        check("reset result", result, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            check($sformatf("vec%0d model", i), model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 255));
                2: b = 32'd0;
                default: b = 32'hFFFF_FFFF;
            endcase
            if (i == 5) a = MIN_NEG;
            run_op(o, a, b, (i == 3), $sformatf("rnd%0d", i));
        end

        // kill during CALC at N+10
        op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check_bit("kill calc busy", busy, 1'b0);
        check_bit("kill calc done", done, 1'b0);
        check("kill calc result", result, last_res);
        wait_quiet(40, "kill calc");
        run_op(OP_REMU, 32'd9, 32'd4, 1'b0, "after kill");
        check("after kill value", last_res, 32'd1);

        // kill during FIX at N+33
        op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (32) tick();
        check_bit("pre-fix busy", busy, 1'b1);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check_bit("kill fix busy", busy, 1'b0);
        check("kill fix result", result, last_res);
        wait_quiet(40, "kill fix");

        // start together with kill is ignored
        op = OP_DIVU; rs1 = 32'd50; rs2 = 32'd5; start = 1'b1; kill = 1'b1;
        tick();
        start = 1'b0; kill = 1'b0;
        check_bit("start+kill busy", busy, 1'b0);
        wait_quiet(40, "start+kill");

        // second start while busy is ignored
        begin
            int cyc;
            op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
            exp_q.push_back(model(OP_DIVU, 32'd100, 32'd7));
            tick();
            start = 1'b0;
            cyc = 1;
            repeat (4) begin tick(); cyc++; end
            op = OP_REMU; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
            tick();
            cyc++;
            start = 1'b0;
            while (!done && cyc < 100) begin tick(); cyc++; end
            check_bit("busy-start done seen", done, 1'b1);
            check("busy-start latency", 32'(cyc), 32'd34);
            if (exp_q.size() > 0) check("busy-start result", result, exp_q.pop_front());
            last_res = result;
            wait_quiet(40, "busy-start");
        end

        // async reset mid-operation after an ignored second start
        op = OP_DIV; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op = OP_DIVU; rs1 = 32'd77; rs2 = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        rst_n = 1'b0;
        #1;
        check_bit("mid reset busy", busy, 1'b0);
        check_bit("mid reset done", done, 1'b0);
        check("mid reset result", result, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_quiet(40, "mid reset");
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, "post reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
